// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Fold an arbitrary target address into the instruction memory range.
  function automatic logic [ADDR_W-1:0] wrap_pc(input logic [ADDR_W-1:0] pc,
                                                 input int unsigned     depth);
    return ADDR_W'(32'(pc) % depth);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs; head is presented straight from a register.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [1:0]   count
);

  fetch_entry_t ent0_q, ent0_d;
  fetch_entry_t ent1_q, ent1_d;
  logic [1:0]   count_q, count_d;

  // Caller guarantees no push when full and no pop when empty.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_d = push_entry;
          else                 ent1_d = push_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_d = push_entry;
          end else begin
            ent0_d = ent1_q;
            ent1_d = push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign head       = ent0_q;
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, fetch state machine and push/redirect arbitration
// in front of a combinational instruction memory.
//
// state  | meaning
// IDLE   | out of reset, waiting one clock before fetching
// FETCH  | fetching one word per cycle while the buffer has room
// HALTED | fetch stopped; buffer drains; only a redirect resumes
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned       IMEM_DEPTH = 1024,
  parameter int unsigned       BUF_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               if_ready,
  output logic               halted
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              push, pop;
  logic [1:0]        count;
  logic              head_valid;
  fetch_entry_t      head, push_entry;

  assign imem_addr  = pc_q;
  assign pop        = head_valid & if_ready;
  assign push       = (state_q == FETCH) & fetch_en & ~redirect_valid & ~halt_req
                      & (count < 2'(BUF_DEPTH));
  assign push_entry = '{pc: pc_q, instr: imem_instr};

  // Redirect outranks everything, including a disabled fetch and a pending halt.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      state_d = FETCH;
      pc_d    = wrap_pc(redirect_pc, IMEM_DEPTH);
    end else if (fetch_en) begin
      if (push) pc_d = (32'(pc_q) == IMEM_DEPTH - 1) ? '0 : pc_q + 16'd1;
      case (state_q)
        IDLE:    state_d = FETCH;
        FETCH:   if (halt_req) state_d = HALTED;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buffer u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_entry (push_entry),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  assign if_valid = head_valid;
  assign if_instr = head.instr;
  assign if_pc    = head.pc;
  assign halted   = (state_q == HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, redirect_valid, halt_req, if_ready;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr, imem_instr;
  logic        if_valid, halted;
  logic [15:0] if_instr, if_pc;

  logic [15:0] mem [1024];
  assign imem_instr = mem[imem_addr[9:0]];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .halted         (halted)
  );

  typedef struct {
    int pc;
    int instr;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  ent_t got[$];
  int   m_pc;
  int   m_mode;  // 0 waiting after reset, 1 running, 2 stopped

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_pc   = 0;
    m_mode = 0;
  endfunction

  function automatic void model_step();
    bit push_ok, pop_ok;
    if (!rst_n) begin
      model_reset();
      return;
    end
    push_ok = (m_mode == 1) && fetch_en && !redirect_valid && !halt_req && (q.size() < 2);
    pop_ok  = (q.size() > 0) && if_ready;
    if (redirect_valid) begin
      q.delete();
      m_pc   = int'(redirect_pc) % 1024;
      m_mode = 1;
      return;
    end
    if (pop_ok) void'(q.pop_front());
    if (push_ok) begin
      q.push_back('{m_pc, int'(mem[m_pc])});
      m_pc = (m_pc + 1) % 1024;
    end
    if (fetch_en) begin
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1 && halt_req) m_mode = 2;
    end
  endfunction

  task automatic compare();
    check("valid", 32'(if_valid), 32'(q.size() > 0));
    check("halted", 32'(halted), 32'(m_mode == 2));
    check("addr", 32'(imem_addr), 32'(m_pc));
    if (q.size() > 0 && if_valid) begin
      check("head_pc", 32'(if_pc), 32'(q[0].pc));
      check("head_instr", 32'(if_instr), 32'(q[0].instr));
    end
  endtask

  // One clock: drive inputs, compare at negedge, advance the model at posedge.
  task automatic cyc(input bit rv, input int rpc, input bit hr, input bit fe, input bit rdy,
                     input bit rst = 1'b1);
    redirect_valid = rv;
    redirect_pc    = rpc[15:0];
    halt_req       = hr;
    fetch_en       = fe;
    if_ready       = rdy;
    rst_n          = rst;
    if (!rst) model_reset();
    @(negedge clk);
    compare();
    if (rst_n && !redirect_valid && if_valid && if_ready)
      got.push_back('{int'(if_pc), int'(if_instr)});
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [15:0] t1_exp [4];
    int n;
    t1_exp = '{16'h0001, 16'h0100, 16'h1590, 16'h1902};
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) mem[i] = t1_exp[i];

    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
    if_ready = 1'b0; redirect_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(if_valid), 0);
    check("rst_instr", 32'(if_instr), 0);
    check("rst_pc", 32'(if_pc), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_addr", 32'(imem_addr), 0);

    // Streaming from reset with decode always ready.
    got.delete();
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 1);
    check("t1_count", 32'(got.size()), 5);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      check("t1_pc", 32'(got[i].pc), 32'(i));
      check("t1_instr", 32'(got[i].instr), 32'(t1_exp[i]));
    end

    // Back-pressure from reset, then release.
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 0);
    check("t2_addr", 32'(imem_addr), 2);
    check("t2_head_pc", 32'(if_pc), 0);
    check("t2_head_instr", 32'(if_instr), 32'h0001);
    got.delete();
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 4 && i < got.size(); i++) check("t2_order", 32'(got[i].pc), 32'(i));
    check("t2_enough", 32'(got.size() >= 4), 1);

    // Redirect while the buffer is full.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
    got.delete();
    cyc(1, 5, 0, 1, 0);
    check("t3_flushed", 32'(if_valid), 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1);
    check("t3_first_pc", 32'(got.size() > 0 ? got[0].pc : -1), 5);

    // Wrap at the top of memory, and out-of-range redirect target.
    got.delete();
    cyc(1, 1023, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1);
    check("t4_last", 32'(got.size() > 1 ? got[0].pc : -1), 1023);
    check("t4_wrap", 32'(got.size() > 1 ? got[1].pc : -1), 0);
    cyc(1, 16'h0401, 0, 1, 1);
    check("t4_redir_wrap", 32'(imem_addr), 1);

    // Halt at pc 4, drain, then resume by redirect.
    cyc(1, 0, 0, 1, 1);
    n = 0;
    while (imem_addr != 16'd4 && n < 20) begin
      cyc(0, 0, 0, 1, 1);
      n++;
    end
    check("t5_reach", 32'(imem_addr), 4);
    got.delete();
    cyc(0, 0, 1, 1, 1);
    check("t5_halted", 32'(halted), 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < got.size(); i++) check("t5_no_new", 32'(got[i].pc < 4), 1);
    check("t5_pc_hold", 32'(imem_addr), 4);
    check("t5_drained", 32'(if_valid), 0);
    cyc(1, 0, 0, 1, 1);
    check("t5_resume", 32'(halted), 0);
    check("t5_resume_pc", 32'(imem_addr), 0);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(if_valid), 0);
    check("t6_addr", 32'(imem_addr), 0);
    check("t6_halted", 32'(halted), 0);
    cyc(0, 0, 0, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 19) == 0, int'($urandom_range(0, 65535)),
          $urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 9) < 7, $urandom_range(0, 499) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
